// File: rtl/adc_agc_ctrl.sv
// adc_agc_ctrl
// Automatic gain control sequencer for one ADC channel.  Tracks the peak
// |sample| of the raw input over windows of window_len valid samples.  After
// each window it steps the front-end attenuator code and the Q8.8 digital gain
// down on overload or a loud window, and up on a quiet window.  When enable is
// low, the register-supplied manual gain and attenuator values pass through.
//
// Ports
//   clk, reset      channel clock, synchronous active-high reset
//   enable          1 = AGC loop runs, 0 = manual passthrough
//   window_len      samples per measurement window (0 behaves as 1)
//   hi_thresh       window peak >= hi_thresh -> step down
//   lo_thresh       window peak <  lo_thresh -> step up (when not held off)
//   manual_gain/att values used while enable is low
//   in, valid_in    signed raw ADC sample and its strobe
//   dor_in          ADC over-range flag, sampled every cycle
//   gain, att       registered gain (Q8.8) and attenuator code (0 = none)
//   peak            peak magnitude of the last completed window
//   peak_valid      1-cycle pulse when peak updates
//   update          1-cycle pulse when the AGC changed gain or att
//   state           0 IDLE, 1 MEASURE, 2 DECIDE
module adc_agc_ctrl #(
    parameter int                    WIDTH        = 8,
    parameter int                    GAIN_WIDTH   = 16,
    parameter logic [GAIN_WIDTH-1:0] GAIN_MIN     = 16'h0040,
    parameter logic [GAIN_WIDTH-1:0] GAIN_MAX     = 16'h1000,
    parameter int                    HOLD_WINDOWS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [23:0]             window_len,
    input  logic [WIDTH-2:0]        hi_thresh,
    input  logic [WIDTH-2:0]        lo_thresh,
    input  logic [GAIN_WIDTH-1:0]   manual_gain,
    input  logic [1:0]              manual_att,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    valid_in,
    input  logic                    dor_in,
    output logic [GAIN_WIDTH-1:0]   gain,
    output logic [1:0]              att,
    output logic [WIDTH-2:0]        peak,
    output logic                    peak_valid,
    output logic                    update,
    output logic [1:0]              state
);

    localparam int HOLD_W = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_WINDOWS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DECIDE  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [GAIN_WIDTH-1:0]   gain_reg;
    logic [1:0]              att_reg;
    logic [WIDTH-2:0]        peak_reg;
    logic                    peak_valid_reg;
    logic                    update_reg;
    logic [23:0]             count_reg;
    logic [WIDTH-2:0]        run_peak_reg;
    logic                    overload_reg;
    logic [HOLD_W-1:0]       hold_reg;

    // ------------------------------------------------------------------
    // Sample magnitude.  The most negative code has no positive twin, so
    // its two's-complement negation lands with the top bit set; that single
    // case saturates to the largest representable magnitude.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] abs_full;
    logic [WIDTH-2:0] mag;

    always_comb begin
        abs_full = in[WIDTH-1] ? (~$unsigned(in) + 1'b1) : $unsigned(in);
        if (abs_full[WIDTH-1]) begin
            mag = '1;
        end else begin
            mag = abs_full[WIDTH-2:0];
        end
    end

    // Index of the sample that closes the window.  A compare of >= rather than
    // == keeps the window bounded if window_len is lowered below the current
    // count mid-window.
    logic [23:0] last_idx;
    logic        window_end;

    assign last_idx   = (window_len == 24'd0) ? 24'd0 : (window_len - 24'd1);
    assign window_end = valid_in && (count_reg >= last_idx);

    // ------------------------------------------------------------------
    // Step decision, evaluated from the completed window's registers.  Only
    // consumed while in DECIDE.
    // ------------------------------------------------------------------
    logic                  go_down;
    logic                  go_up;
    logic [GAIN_WIDTH-1:0] gain_half;
    logic [GAIN_WIDTH-1:0] down_gain;
    logic [GAIN_WIDTH:0]   gain_dbl;
    logic [GAIN_WIDTH-1:0] up_gain;
    logic [GAIN_WIDTH-1:0] agc_gain_next;
    logic [1:0]            agc_att_next;

    assign go_down   = overload_reg || (run_peak_reg >= hi_thresh);
    assign go_up     = (run_peak_reg < lo_thresh) && (hold_reg == '0);
    assign gain_half = {1'b0, gain_reg[GAIN_WIDTH-1:1]};
    assign down_gain = (gain_half < GAIN_MIN) ? GAIN_MIN : gain_half;
    // Doubling is done one bit wider so a large gain clamps instead of wrapping.
    assign gain_dbl  = {gain_reg, 1'b0};
    assign up_gain   = (gain_dbl > {1'b0, GAIN_MAX}) ? GAIN_MAX : gain_dbl[GAIN_WIDTH-1:0];

    always_comb begin
        agc_gain_next = gain_reg;
        agc_att_next  = att_reg;
        if (go_down) begin
            // Digital gain is backed off first; the attenuator only engages
            // once the gain sits at its floor.
            if (gain_reg > GAIN_MIN) begin
                agc_gain_next = down_gain;
            end else if (att_reg != 2'd3) begin
                agc_att_next = att_reg + 2'd1;
            end
        end else if (go_up) begin
            // Attenuation is removed before any digital gain is added.
            if (att_reg != 2'd0) begin
                agc_att_next = att_reg - 2'd1;
            end else begin
                agc_gain_next = up_gain;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            gain_reg       <= 16'h0100;
            att_reg        <= 2'd0;
            peak_reg       <= '0;
            peak_valid_reg <= 1'b0;
            update_reg     <= 1'b0;
            count_reg      <= '0;
            run_peak_reg   <= '0;
            overload_reg   <= 1'b0;
            hold_reg       <= '0;
        end else begin
            peak_valid_reg <= 1'b0;
            update_reg     <= 1'b0;

            if (!enable) begin
                // Any partial window is thrown away.  Manual values are only
                // loaded once IDLE is reached, so they appear one cycle later.
                state_reg    <= ST_IDLE;
                hold_reg     <= '0;
                count_reg    <= '0;
                run_peak_reg <= '0;
                overload_reg <= 1'b0;
                if (state_reg == ST_IDLE) begin
                    gain_reg <= manual_gain;
                    att_reg  <= manual_att;
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        gain_reg     <= manual_gain;
                        att_reg      <= manual_att;
                        count_reg    <= '0;
                        run_peak_reg <= '0;
                        overload_reg <= 1'b0;
                        state_reg    <= ST_MEASURE;
                    end

                    ST_MEASURE: begin
                        if (dor_in) begin
                            overload_reg <= 1'b1;
                        end
                        if (valid_in) begin
                            if (mag > run_peak_reg) begin
                                run_peak_reg <= mag;
                            end
                            count_reg <= count_reg + 24'd1;
                            if (window_end) begin
                                state_reg <= ST_DECIDE;
                            end
                        end
                    end

                    ST_DECIDE: begin
                        // Samples arriving in this cycle are intentionally
                        // ignored; the next window starts clean.
                        peak_reg       <= run_peak_reg;
                        peak_valid_reg <= 1'b1;
                        gain_reg       <= agc_gain_next;
                        att_reg        <= agc_att_next;
                        update_reg     <= (agc_gain_next != gain_reg) ||
                                          (agc_att_next != att_reg);
                        if (go_down) begin
                            hold_reg <= HOLD_LOAD;
                        end else if (!go_up && (hold_reg != '0)) begin
                            hold_reg <= hold_reg - 1'b1;
                        end
                        count_reg    <= '0;
                        run_peak_reg <= '0;
                        overload_reg <= 1'b0;
                        state_reg    <= ST_MEASURE;
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign gain       = gain_reg;
    assign att        = att_reg;
    assign peak       = peak_reg;
    assign peak_valid = peak_valid_reg;
    assign update     = update_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_adc_agc_ctrl.sv
// Testbench for adc_agc_ctrl: a table of hand-computed windows, a few
// hand-written multi-cycle sequences, then randomized windows checked against
// a window-level reference model.
module tb_adc_agc_ctrl;

    localparam int MIN  = 'h0040;
    localparam int MAX  = 'h1000;
    localparam int HOLD = 4;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [23:0] window_len;
    logic [6:0]  hi_thresh;
    logic [6:0]  lo_thresh;
    logic [15:0] manual_gain;
    logic [1:0]  manual_att;
    logic signed [7:0] in;
    logic        valid_in;
    logic        dor_in;
    logic [15:0] gain;
    logic [1:0]  att;
    logic [6:0]  peak;
    logic        peak_valid;
    logic        update;
    logic [1:0]  state;

    adc_agc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .window_len  (window_len),
        .hi_thresh   (hi_thresh),
        .lo_thresh   (lo_thresh),
        .manual_gain (manual_gain),
        .manual_att  (manual_att),
        .in          (in),
        .valid_in    (valid_in),
        .dor_in      (dor_in),
        .gain        (gain),
        .att         (att),
        .peak        (peak),
        .peak_valid  (peak_valid),
        .update      (update),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: inputs change 1 time unit after the rising edge,
    // and the task returns 1 unit after the next rising edge.
    task automatic drive(input int v, input logic vl, input logic d);
        in       = v[7:0];
        valid_in = vl;
        dor_in   = d;
        @(posedge clk);
        #1;
    endtask

    // ---------------- window-level reference model ----------------
    int m_g, m_a, m_h, m_upd;

    function automatic int magnitude(input int s);
        int a;
        a = (s < 0) ? -s : s;
        if (a > 127) a = 127;
        return a;
    endfunction

    function automatic void model_decide(input int pk, input bit ovl);
        int g0;
        int a0;
        g0 = m_g;
        a0 = m_a;
        if (ovl || pk >= int'(hi_thresh)) begin
            if (m_g > MIN) m_g = (m_g / 2 < MIN) ? MIN : m_g / 2;
            else if (m_a < 3) m_a = m_a + 1;
            m_h = HOLD;
        end else if (pk < int'(lo_thresh) && m_h == 0) begin
            if (m_a > 0) m_a = m_a - 1;
            else m_g = (m_g * 2 > MAX) ? MAX : m_g * 2;
        end else if (m_h > 0) begin
            m_h = m_h - 1;
        end
        m_upd = (m_g != g0 || m_a != a0) ? 1 : 0;
    endfunction

    // ---------------- window driver ----------------
    int win_s[$];
    bit win_d[$];
    int win_gap[$];

    task automatic run_window(input string tag, input int pk, input int g, input int a, input int u);
        for (int i = 0; i < win_s.size(); i++) begin
            for (int k = 0; k < win_gap[i]; k++) drive(0, 1'b0, win_d[i]);
            drive(win_s[i], 1'b1, win_d[i]);
        end
        check($sformatf("%s.state_decide", tag), state, 2);
        drive(0, 1'b0, 1'b0);
        check($sformatf("%s.peak_valid", tag), peak_valid, 1);
        check($sformatf("%s.peak", tag), peak, pk);
        check($sformatf("%s.gain", tag), gain, g);
        check($sformatf("%s.att", tag), att, a);
        check($sformatf("%s.update", tag), update, u);
        check($sformatf("%s.state_measure", tag), state, 1);
        drive(0, 1'b0, 1'b0);
        check($sformatf("%s.pv_pulse", tag), peak_valid, 0);
        check($sformatf("%s.upd_pulse", tag), update, 0);
        $display("window %s: peak=%0d gain=0x%0h att=%0d update=%0d", tag, peak, gain, att, u);
        win_s.delete();
        win_d.delete();
        win_gap.delete();
    endtask

    task automatic load_window(input int s0, input int s1, input int s2, input int s3, input int dm);
        int s[4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            win_s.push_back(s[i]);
            win_d.push_back(dm[i]);
            win_gap.push_back(0);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [3:0][7:0] s;
        logic [3:0]      dmask;
        logic [6:0]      pk;
        logic [15:0]     g;
        logic [1:0]      a;
        logic            upd;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mkv(input int s0, input int s1, input int s2, input int s3,
                                 input int dm, input int pk, input int g, input int a, input int u);
        vec_t v;
        v.s[0]  = s0[7:0];
        v.s[1]  = s1[7:0];
        v.s[2]  = s2[7:0];
        v.s[3]  = s3[7:0];
        v.dmask = dm[3:0];
        v.pk    = pk[6:0];
        v.g     = g[15:0];
        v.a     = a[1:0];
        v.upd   = u[0];
        return v;
    endfunction

    int pick_gain;
    int wl, n, pk, g_sel;
    bit ovl;

    initial begin
        // Window length 4, hi=100, lo=20; starting from gain 0x0100, att 0, hold 0.
        tbl[0]  = mkv(5, -90, 30, -128, 0, 127, 'h0080, 0, 1);   // loud: halve gain, hold=4
        tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 'h0080, 0, 0);           // held 4->3
        tbl[2]  = mkv(0, 0, 0, 0, 0, 0, 'h0080, 0, 0);           // 3->2
        tbl[3]  = mkv(0, 0, 0, 0, 0, 0, 'h0080, 0, 0);           // 2->1
        tbl[4]  = mkv(0, 0, 0, 0, 0, 0, 'h0080, 0, 0);           // 1->0
        tbl[5]  = mkv(0, 0, 0, 0, 0, 0, 'h0100, 0, 1);           // hold expired: double
        tbl[6]  = mkv(20, -20, 0, 0, 0, 20, 'h0100, 0, 0);       // peak == lo: no step
        tbl[7]  = mkv(99, -99, 1, 0, 0, 99, 'h0100, 0, 0);       // just under hi
        tbl[8]  = mkv(-100, 0, 0, 0, 0, 100, 'h0080, 0, 1);      // peak == hi: down
        tbl[9]  = mkv(10, 3, -4, 2, 4'b0010, 10, 'h0040, 0, 1);  // over-range forces down
        tbl[10] = mkv(127, -127, 0, 0, 0, 127, 'h0040, 1, 1);    // gain at floor: att up
        tbl[11] = mkv(-128, 0, 0, 0, 0, 127, 'h0040, 2, 1);
        tbl[12] = mkv(127, 0, 0, 0, 0, 127, 'h0040, 3, 1);
        tbl[13] = mkv(127, 0, 0, 0, 0, 127, 'h0040, 3, 0);       // att saturated
        tbl[14] = mkv(0, 0, 0, 0, 0, 0, 'h0040, 3, 0);
        tbl[15] = mkv(0, 0, 0, 0, 0, 0, 'h0040, 3, 0);
        tbl[16] = mkv(0, 0, 0, 0, 0, 0, 'h0040, 3, 0);
        tbl[17] = mkv(0, 0, 0, 0, 0, 0, 'h0040, 3, 0);
        tbl[18] = mkv(0, 0, 0, 0, 0, 0, 'h0040, 2, 1);           // att removed first
        tbl[19] = mkv(0, 0, 0, 0, 0, 0, 'h0040, 1, 1);
        tbl[20] = mkv(0, 0, 0, 0, 0, 0, 'h0040, 0, 1);
        tbl[21] = mkv(0, 0, 0, 0, 0, 0, 'h0080, 0, 1);
        tbl[22] = mkv(0, 0, 0, 0, 0, 0, 'h0100, 0, 1);
        tbl[23] = mkv(0, 0, 0, 0, 0, 0, 'h0200, 0, 1);
        tbl[24] = mkv(0, 0, 0, 0, 0, 0, 'h0400, 0, 1);
        tbl[25] = mkv(0, 0, 0, 0, 0, 0, 'h0800, 0, 1);
        tbl[26] = mkv(0, 0, 0, 0, 0, 0, 'h1000, 0, 1);
        tbl[27] = mkv(0, 0, 0, 0, 0, 0, 'h1000, 0, 0);           // clamped at max

        reset       = 1'b1;
        enable      = 1'b0;
        window_len  = 24'd4;
        hi_thresh   = 7'd100;
        lo_thresh   = 7'd20;
        manual_gain = 16'h0280;
        manual_att  = 2'd2;
        in          = '0;
        valid_in    = 1'b0;
        dor_in      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.state", state, 0);
        check("reset.gain", gain, 'h0100);
        check("reset.att", att, 0);
        check("reset.peak", peak, 0);
        check("reset.peak_valid", peak_valid, 0);
        check("reset.update", update, 0);

        // Manual passthrough.
        reset = 1'b0;
        drive(0, 1'b0, 1'b0);
        check("manual.gain", gain, 'h0280);
        check("manual.att", att, 2);
        check("manual.state", state, 0);
        $display("manual: gain=0x%0h att=%0d", gain, att);

        // Enter AGC from manual 0x0100 / 0.
        manual_gain = 16'h0100;
        manual_att  = 2'd0;
        enable      = 1'b1;
        drive(0, 1'b0, 1'b0);
        check("enter.state", state, 1);
        check("enter.gain", gain, 'h0100);
        check("enter.att", att, 0);

        for (int i = 0; i < 28; i++) begin
            load_window($signed(tbl[i].s[0]), $signed(tbl[i].s[1]), $signed(tbl[i].s[2]),
                        $signed(tbl[i].s[3]), int'(tbl[i].dmask));
            run_window($sformatf("tbl%0d", i), int'(tbl[i].pk), int'(tbl[i].g),
                       int'(tbl[i].a), int'(tbl[i].upd));
        end

        // Loud window at 0x1000 arms the hold-off, then enable drops mid-window.
        load_window(127, 0, 0, 0, 0);
        run_window("pre_drop", 127, 'h0800, 0, 1);
        manual_gain = 16'h0C00;
        manual_att  = 2'd0;
        drive(3, 1'b1, 1'b0);
        drive(4, 1'b1, 1'b0);
        enable = 1'b0;
        drive(0, 1'b0, 1'b0);
        check("drop.state", state, 0);
        check("drop.peak_valid", peak_valid, 0);
        drive(0, 1'b0, 1'b0);
        check("drop.gain", gain, 'h0C00);
        check("drop.att", att, 0);
        check("drop.peak_valid2", peak_valid, 0);
        $display("drop: state=%0d gain=0x%0h", state, gain);
        enable = 1'b1;
        drive(0, 1'b0, 1'b0);
        check("reenter.state", state, 1);
        // Hold-off was cleared by the drop, so a quiet window steps up at once.
        load_window(3, -3, 1, 0, 0);
        run_window("quiet_c00", 3, 'h1000, 0, 1);
        load_window(3, 0, -2, 0, 0);
        run_window("quiet_max", 3, 'h1000, 0, 0);

        // Zero-length window behaves as a single-sample window.
        window_len = 24'd0;
        win_s.push_back(50);   win_d.push_back(0); win_gap.push_back(0);
        run_window("wl0_a", 50, 'h1000, 0, 0);
        win_s.push_back(-7);   win_d.push_back(0); win_gap.push_back(0);
        run_window("wl0_b", 7, 'h1000, 0, 0);
        win_s.push_back(127);  win_d.push_back(0); win_gap.push_back(0);
        run_window("wl0_c", 127, 'h0800, 0, 1);

        // Reset in the middle of operation.
        drive(9, 1'b1, 1'b0);
        reset  = 1'b1;
        enable = 1'b0;
        drive(0, 1'b0, 1'b0);
        check("midreset.state", state, 0);
        check("midreset.gain", gain, 'h0100);
        check("midreset.att", att, 0);
        check("midreset.peak", peak, 0);
        reset = 1'b0;

        // ---------------- randomized windows vs. model ----------------
        for (int w = 0; w < 80; w++) begin
            if (w == 0 || $urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                g_sel  = $urandom_range(0, 5);
                case (g_sel)
                    0: pick_gain = 'h0100;
                    1: pick_gain = 'h0040;
                    2: pick_gain = 'h0020;
                    3: pick_gain = 'h1000;
                    4: pick_gain = 'h3000;
                    default: pick_gain = $urandom_range(0, 65535);
                endcase
                manual_gain = pick_gain[15:0];
                manual_att  = 2'($urandom_range(0, 3));
                drive(0, 1'b0, 1'b0);
                drive(0, 1'b0, 1'b0);
                check($sformatf("rnd%0d.idle_state", w), state, 0);
                check($sformatf("rnd%0d.idle_gain", w), gain, pick_gain);
                check($sformatf("rnd%0d.idle_att", w), att, manual_att);
                enable = 1'b1;
                drive(0, 1'b0, 1'b0);
                check($sformatf("rnd%0d.enter", w), state, 1);
                m_g = pick_gain;
                m_a = int'(manual_att);
                m_h = 0;
            end
            wl = $urandom_range(0, 5);
            window_len = 24'(wl);
            if ($urandom_range(0, 3) == 0) begin
                hi_thresh = 7'($urandom_range(0, 127));
                lo_thresh = 7'($urandom_range(0, 127));
            end else begin
                hi_thresh = 7'($urandom_range(40, 127));
                lo_thresh = 7'($urandom_range(0, 60));
            end
            n   = (wl == 0) ? 1 : wl;
            pk  = 0;
            ovl = 1'b0;
            for (int i = 0; i < n; i++) begin
                int s;
                bit d;
                if ($urandom_range(0, 2) == 0) s = int'($urandom_range(0, 255)) - 128;
                else s = int'($urandom_range(0, 40)) - 20;
                d = ($urandom_range(0, 9) == 0);
                win_s.push_back(s);
                win_d.push_back(d);
                win_gap.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
                if (magnitude(s) > pk) pk = magnitude(s);
                ovl = ovl | d;
            end
            model_decide(pk, ovl);
            run_window($sformatf("rnd%0d", w), pk, m_g, m_a, m_upd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
